inv_out_debounce: RTL

//  Consumer stage for the switch-level inverter output net (pmos/nmos pair with pullup/pulldown).

---
 rtl/inv_out_debounce_pkg.sv | 34 +++
 rtl/inv_out_debounce_sync.sv | 31 +++
 rtl/inv_out_debounce.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/inv_out_debounce_pkg.sv
// ----------------------------------------------------------------------------
// inv_out_debounce_pkg
// Shared types and helpers for the inverter-output debouncer.
//   dbn_state_t   : two-state qualification FSM encoding
//   GCNT_MAX_DEF  : saturation value of the default-width glitch counter
//   clog2_f       : ceiling log2 used to size the qualification counter
// ----------------------------------------------------------------------------
package inv_out_debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_QUAL   = 1'b1
    } dbn_state_t;

    localparam logic [7:0] GCNT_MAX_DEF = 8'hFF;

    // Ceiling log2, never below 1 so a counter vector is always at least
    // one bit wide.
    function automatic int clog2_f(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/inv_out_debounce_sync.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser bringing the raw inverter net into the clk domain.
//   clk : clock, all state on posedge
//   rst : asynchronous active-high reset, flops clear to 0
//   d   : asynchronous input
//   q   : synchronised output (second flop)
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int STAGES = 2;

    // stage_reg[0] is s1 (first capture), stage_reg[STAGES-1] is s2.
    logic [STAGES-1:0] stage_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/inv_out_debounce.sv
// ----------------------------------------------------------------------------
// inv_out_debounce
// Consumer stage for the switch-level inverter output net. Synchronises the
// resolved 1-bit net, rejects glitches caused by unequal pmos/nmos edge
// delays, and emits a debounced level with one-cycle rise/fall strobes.
//
// Parameters
//   STABLE_CYCLES : consecutive synced samples differing from dout needed
//                   before dout flips (2..255)
//   GCNT_W        : width of the saturating glitch counter
// Ports
//   clk        in  1       clock, all state on posedge
//   rst        in  1       asynchronous active-high reset
//   din        in  1       raw inverter output net
//   dout       out 1       debounced level
//   rise       out 1       one-cycle pulse on dout 0->1
//   fall       out 1       one-cycle pulse on dout 1->0
//   busy       out 1       high while a candidate transition is qualifying
//   glitch_cnt out GCNT_W  rejected-transition count, saturating
//
// Build option
//   INV_OUT_DEBOUNCE_GLITCH_CNT_EN : when defined the glitch counter is
//   built; when undefined glitch_cnt is tied to 0 (port kept).
// ----------------------------------------------------------------------------
module inv_out_debounce
    import inv_out_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int GCNT_W        = $bits(GCNT_MAX_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic              dout,
    output logic              rise,
    output logic              fall,
    output logic              busy,
    output logic [GCNT_W-1:0] glitch_cnt
);

    localparam int              CNT_W    = clog2_f(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Elaboration-time guard on the qualification length.
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
        $fatal(1, "inv_out_debounce: STABLE_CYCLES=%0d outside 2..255", STABLE_CYCLES);
    end

    // ------------------------------------------------------------------
    // Synchroniser: only the second flop output is visible to the FSM.
    // ------------------------------------------------------------------
    logic s2;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (s2)
    );

    // ------------------------------------------------------------------
    // Qualification FSM
    // ------------------------------------------------------------------
    dbn_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic             dout_reg,  dout_next;
    logic             rise_reg,  rise_next;
    logic             fall_reg,  fall_next;
    logic             busy_reg,  busy_next;
    logic             glitch_evt;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dout_next  = dout_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        glitch_evt = 1'b0;

        case (state_reg)
            ST_STABLE: begin
                if (s2 != dout_reg) begin
                    // First differing sample counts as sample #1.
                    state_next = ST_QUAL;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end

            ST_QUAL: begin
                if (s2 != dout_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        // This is the STABLE_CYCLES-th differing sample.
                        dout_next  = ~dout_reg;
                        rise_next  = ~dout_reg;
                        fall_next  = dout_reg;
                        state_next = ST_STABLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next   = cnt_reg + CNT_ONE;
                    end
                end else begin
                    // Net fell back before qualifying: reject as a glitch.
                    glitch_evt = 1'b1;
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end
            end

            default: begin
                state_next = ST_STABLE;
                cnt_next   = '0;
            end
        endcase

        // busy is a flop that tracks the FSM state it will be in.
        busy_next = (state_next == ST_QUAL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_STABLE;
            cnt_reg   <= '0;
            dout_reg  <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dout_reg  <= dout_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            busy_reg  <= busy_next;
        end
    end

    assign dout = dout_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;
    assign busy = busy_reg;

    // ------------------------------------------------------------------
    // Glitch counter (optional)
    // ------------------------------------------------------------------
`ifdef INV_OUT_DEBOUNCE_GLITCH_CNT_EN
    logic [GCNT_W-1:0] gcnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_reg <= '0;
        end else if (glitch_evt && (gcnt_reg != {GCNT_W{1'b1}})) begin
            // Saturate at all-ones instead of wrapping.
            gcnt_reg <= gcnt_reg + 1'b1;
        end
    end

    assign glitch_cnt = gcnt_reg;
`else
    logic unused_glitch_evt;

    assign unused_glitch_evt = glitch_evt;
    assign glitch_cnt        = '0;
`endif

endmodule
